// File: rtl/core_mem_arb.sv
// core_mem_arb: 2:1 IFU/LSU arbiter onto one shared memory port, one transaction in flight
module core_mem_arb #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int ARB_MODE = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_rsp_valid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic                i_lsu_wen,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  output logic                o_lsu_rsp_valid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  input  logic                i_mem_rsp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);
  localparam int STRB_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e              state_q, state_d;
  logic                grant_lsu_q, grant_lsu_d;
  logic                last_lsu_q, last_lsu_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                ifu_rsp_q, ifu_rsp_d, lsu_rsp_q, lsu_rsp_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic                any_req, pick_lsu;
  // On a tie: fixed priority favours the LSU, round-robin favours whoever lost last time
  always_comb begin
    any_req  = i_ifu_req_valid | i_lsu_req_valid;
    pick_lsu = (i_ifu_req_valid & i_lsu_req_valid) ? ((ARB_MODE == 0) ? 1'b1 : ~last_lsu_q) : i_lsu_req_valid;
  end
  always_comb begin
    state_d         = state_q;
    grant_lsu_d     = grant_lsu_q;
    last_lsu_d      = last_lsu_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    ifu_rsp_d       = 1'b0;
    lsu_rsp_d       = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    lsu_rdata_d     = lsu_rdata_q;
    o_ifu_req_ready = 1'b0;
    o_lsu_req_ready = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        o_lsu_req_ready = pick_lsu;
        o_ifu_req_ready = ~pick_lsu;
        grant_lsu_d     = pick_lsu;
        last_lsu_d      = pick_lsu;
        addr_d          = pick_lsu ? i_lsu_addr : i_ifu_addr;
        wen_d           = pick_lsu & i_lsu_wen;
        wdata_d         = pick_lsu ? i_lsu_wdata : '0;
        wstrb_d         = pick_lsu ? i_lsu_wstrb : '0;
        state_d         = REQ;
      end
      REQ: if (i_mem_req_ready) state_d = WAIT;
      WAIT: if (i_mem_rsp_valid) begin
        ifu_rsp_d   = ~grant_lsu_q;
        lsu_rsp_d   = grant_lsu_q;
        ifu_rdata_d = grant_lsu_q ? ifu_rdata_q : i_mem_rdata;
        lsu_rdata_d = grant_lsu_q ? i_mem_rdata : lsu_rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      grant_lsu_q <= 1'b0;
      last_lsu_q  <= 1'b1;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_lsu_q <= grant_lsu_d;
      last_lsu_q  <= last_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ifu_rsp_q   <= ifu_rsp_d;
      lsu_rsp_q   <= lsu_rsp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end
  assign o_mem_req_valid = (state_q == REQ);
  assign o_mem_addr      = addr_q;
  assign o_mem_wen       = wen_q;
  assign o_mem_wdata     = wdata_q;
  assign o_mem_wstrb     = wstrb_q;
  assign o_ifu_rsp_valid = ifu_rsp_q;
  assign o_ifu_rdata     = ifu_rdata_q;
  assign o_lsu_rsp_valid = lsu_rsp_q;
  assign o_lsu_rdata     = lsu_rdata_q;
endmodule
